ntt_frame_reorder: RTL and testbench

NTT_FRAME_REORDER -- requirements
Module: ntt_frame_reorder

---
 rtl/ntt_pkg.sv | 24 ++
 rtl/ntt_bitrev.sv | 16 +
 rtl/ntt_frame_reorder.sv | 102 ++++++++++
 tb/tb_ntt_frame_reorder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared defaults, log2 helper and bank-state encoding for the NTT frame reorder buffer.
package ntt_pkg;

  localparam int unsigned DEF_N     = 128;
  localparam int unsigned DEF_CW    = 4;
  localparam int unsigned DEF_LANES = 8;
  localparam int unsigned DEF_OW    = 16;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  function automatic int unsigned log2_ceil(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_bitrev.sv
// Combinational bit reversal of a WIDTH-bit index.
module ntt_bitrev #(
  parameter int unsigned WIDTH = 7
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dout[i] = din[WIDTH-1-i];
    end
  end

endmodule

// File: rtl/ntt_frame_reorder.sv
// Ping-pong frame buffer: fills LANES coefficients per beat, drains one coefficient per
// cycle in natural or bit-reversed order. Handshakes: a transfer happens on a rising clk
// edge where valid&ready are both high; valid never depends on ready on either port.
module ntt_frame_reorder
  import ntt_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned CW    = DEF_CW,
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned OW    = DEF_OW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*CW-1:0]   in_data,
  input  logic                  in_bitrev,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OW-1:0]         out_data,
  output logic                  out_last
);

  localparam int unsigned LW    = log2_ceil(N);
  localparam int unsigned BEATS = N / LANES;
  localparam int unsigned BCW   = (BEATS > 1) ? log2_ceil(BEATS) : 1;

  logic [CW-1:0]  mem [2][N];
  bank_state_t    bank_state [2];
  logic           bank_rev [2];
  logic           fill_ptr;
  logic           drain_ptr;
  logic [BCW-1:0] beat_cnt;
  logic [LW-1:0]  k;
  logic [LW-1:0]  k_rev;
  logic [LW-1:0]  rd_idx;
  logic           in_fire;
  logic           out_fire;
  logic           beat_last;
  logic           k_last;

  // Fill and drain never target the same bank in one cycle: a bank is drained only once FULL,
  // and a FULL bank is never the fill target.
  assign in_ready  = (bank_state[fill_ptr] != BANK_FULL);
  assign out_valid = (bank_state[drain_ptr] == BANK_FULL);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign beat_last = (beat_cnt == BCW'(BEATS - 1));
  assign k_last    = (k == LW'(N - 1));

  ntt_bitrev #(.WIDTH(LW)) u_bitrev (
    .din  (k),
    .dout (k_rev)
  );

  assign rd_idx   = bank_rev[drain_ptr] ? k_rev : k;
  assign out_data = out_valid ? OW'(mem[drain_ptr][rd_idx]) : '0;
  assign out_last = out_valid & k_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_state[0] <= BANK_EMPTY;
      bank_state[1] <= BANK_EMPTY;
      bank_rev[0]   <= 1'b0;
      bank_rev[1]   <= 1'b0;
      fill_ptr      <= 1'b0;
      drain_ptr     <= 1'b0;
      beat_cnt      <= '0;
      k             <= '0;
    end else begin
      if (in_fire) begin
        beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
        if (beat_cnt == '0) bank_rev[fill_ptr] <= in_bitrev;
        if (beat_last) begin
          bank_state[fill_ptr] <= BANK_FULL;
          fill_ptr             <= ~fill_ptr;
        end else begin
          bank_state[fill_ptr] <= BANK_FILLING;
        end
      end
      if (out_fire) begin
        if (k_last) begin
          k                     <= '0;
          bank_state[drain_ptr] <= BANK_EMPTY;
          drain_ptr             <= ~drain_ptr;
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

  // Storage is left uncleared by reset; the FULL flags alone decide what is visible.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int j = 0; j < LANES; j++) begin
        mem[fill_ptr][LW'(int'(beat_cnt) * LANES + j)] <= in_data[j*CW +: CW];
      end
    end
  end

endmodule

// File: tb/tb_ntt_frame_reorder.sv
// Directed bench for ntt_frame_reorder with a scoreboard of expected {last, data} outputs.
module tb_ntt_frame_reorder;

  localparam int N     = 128;
  localparam int CW    = 4;
  localparam int LANES = 8;
  localparam int OW    = 16;
  localparam int BEATS = N / LANES;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [LANES*CW-1:0] in_data;
  logic                in_bitrev;
  logic                out_valid;
  logic                out_ready;
  logic [OW-1:0]       out_data;
  logic                out_last;

  ntt_frame_reorder #(.N(N), .CW(CW), .LANES(LANES), .OW(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bitrev (in_bitrev),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [OW:0] exp_q[$];
  logic [CW-1:0] fr [N];
  bit watch_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int rev7(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 7; b++) if (((k >> b) & 1) != 0) r = r | (1 << (6 - b));
    return r;
  endfunction

  task automatic fill_natural();
    for (int i = 0; i < N; i++) fr[i] = CW'(i % 16);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) fr[i] = CW'($urandom_range(0, 15));
  endtask

  task automatic push_frame(input bit rev);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = rev ? rev7(k) : k;
      exp_q.push_back({(k == N - 1), OW'(fr[idx])});
    end
  endtask

  // driver: called at posedge+1; returns at posedge+1 after beat 'last' is accepted
  task automatic send_beats(input bit rev, input int first, input int last);
    int wait_cyc;
    for (int b = first; b <= last; b++) begin
      in_valid  = 1'b1;
      in_bitrev = (b == 0) ? rev : ~rev;
      for (int j = 0; j < LANES; j++) in_data[j*CW +: CW] = fr[b*LANES + j];
      wait_cyc = 0;
      while (!in_ready && wait_cyc < 400) begin
        @(posedge clk); #1;
        wait_cyc++;
      end
      if (!in_ready) begin
        check("beat_timeout", 32'(wait_cyc), 32'd0);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = $urandom();
    if (last == BEATS - 1) push_frame(rev);
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [OW:0] e;
    if (watch_valid) check("no_gap", 32'(out_valid), 32'd1);
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e[OW-1:0]));
        check("out_last", 32'(out_last), 32'(e[OW]));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_bitrev = 1'b0;
    out_ready = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // natural mode, first-output latency
    fill_natural();
    send_beats(1'b0, 0, BEATS - 2);
    check("valid_before_last_beat", 32'(out_valid), 32'd0);
    send_beats(1'b0, BEATS - 1, BEATS - 1);
    check("first_valid_latency", 32'(out_valid), 32'd1);
    wait_drain();

    // bit-reversed mode; k=1 reads index 64
    fill_natural();
    send_beats(1'b1, 0, BEATS - 1);
    check("bitrev_k0", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    check("bitrev_k1", 32'(out_data), 32'd0);
    wait_drain();

    // backpressure: two frames fill both banks, third is refused
    out_ready = 1'b0;
    fill_random();
    send_beats(1'b0, 0, BEATS - 1);
    fill_random();
    send_beats(1'b1, 0, BEATS - 1);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data", 32'(out_data), 32'(exp_q[0][OW-1:0]));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 1; i <= N; i++) begin
      @(posedge clk); #1;
      if (i == N - 1) check("in_ready_before_last", 32'(in_ready), 32'd0);
      if (i == N) begin
        check("in_ready_after_last", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
      end
    end
    fill_random();
    send_beats(1'b0, 0, BEATS - 1);
    wait_drain();

    // back-to-back: frame B final beat meets frame A out_last
    fill_random();
    send_beats(1'b0, 0, BEATS - 1);
    watch_valid = 1'b1;
    repeat (N - BEATS) @(posedge clk);
    #1;
    fill_random();
    send_beats(1'b1, 0, BEATS - 1);
    check("b2b_queue", 32'(exp_q.size()), 32'(N));
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_first", 32'(out_data), 32'(exp_q[0][OW-1:0]));
    wait_drain();
    watch_valid = 1'b0;

    // reset in the middle of a fill discards the partial frame
    fill_random();
    send_beats(1'b0, 0, 6);
    rst = 1'b1;
    #1;
    check("midfill_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("midfill_no_output", 32'(out_valid), 32'd0);
    check("midfill_in_ready", 32'(in_ready), 32'd1);
    fill_random();
    send_beats(1'b1, 0, BEATS - 1);
    wait_drain();

    // asynchronous reset while a frame is draining
    fill_random();
    send_beats(1'b0, 0, BEATS - 1);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("drain_rst_valid", 32'(out_valid), 32'd0);
    check("drain_rst_data", 32'(out_data), 32'd0);
    check("drain_rst_last", 32'(out_last), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("drain_rel_in_ready", 32'(in_ready), 32'd1);
    fill_natural();
    send_beats(1'b0, 0, BEATS - 1);
    wait_drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
